// File: rtl/cim_pipeline_seq.sv
// cim_pipeline_seq: sequencer for a chain of CIM layers (conv/pool/fc).
// Each layer walks IDLE -> RUN -> DONE. A finished layer hands its frame to
// the next layer, and the last layer hands it to the result consumer.
// A layer that is released and refilled on the same edge goes DONE -> RUN
// directly, so a hand-off adds no bubble cycle.
// Optional build macro CIM_PIPELINE_PERF_CNT_EN adds saturating per-layer
// RUN-cycle counters. Without it, o_run_cycles is tied to zero.
module cim_pipeline_seq #(
  parameter int num_layers      = 7,
  parameter int frame_cnt_width = 16,
  parameter int cycle_cnt_width = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_frame_valid,
  output logic                                  o_frame_ready,
  output logic [num_layers-1:0]                 o_layer_start,
  input  logic [num_layers-1:0]                 i_layer_done,
  output logic [num_layers-1:0]                 o_next_busy,
  output logic                                  o_result_valid,
  input  logic                                  i_result_ready,
  output logic [frame_cnt_width-1:0]            o_frame_cnt,
  output logic                                  o_idle,
  output logic                                  o_err,
  output logic [num_layers*cycle_cnt_width-1:0] o_run_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [num_layers-1:0]      idle_vec;
  logic [num_layers-1:0]      done_vec;
  logic [num_layers-1:0]      done_ok_vec;
  logic                       retire;
  logic [frame_cnt_width-1:0] frame_cnt_reg;
  logic                       err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < num_layers; gi++) begin : g_layer
      state_t state_reg;
      logic   start_reg;
      logic   avail_w;    // a frame is waiting at this layer's input
      logic   release_w;  // downstream takes this layer's result on this edge
      logic   start_w;    // this layer starts a frame on this edge

      if (gi == 0) begin : g_first
        assign avail_w = i_frame_valid;
      end else begin : g_chain
        assign avail_w = (g_layer[gi-1].state_reg == ST_DONE);
      end

      if (gi == num_layers - 1) begin : g_last
        assign release_w = (state_reg == ST_DONE) && i_result_ready;
      end else begin : g_mid
        assign release_w = g_layer[gi+1].start_w;
      end

      // A layer can start when it is empty, or when it is DONE and is
      // emptied on this same edge.
      assign start_w = avail_w &&
                       ((state_reg == ST_IDLE) ||
                        ((state_reg == ST_DONE) && release_w));

      assign idle_vec[gi]      = (state_reg == ST_IDLE);
      assign done_vec[gi]      = (state_reg == ST_DONE);
      assign o_layer_start[gi] = start_reg;
      // A done pulse is honoured only in RUN and outside the start-pulse cycle.
      assign done_ok_vec[gi]   = (state_reg == ST_RUN) && !start_reg;

      if (gi == num_layers - 1) begin : g_busy_last
        assign o_next_busy[gi] = ~i_result_ready;
      end else begin : g_busy_mid
        assign o_next_busy[gi] = (g_layer[gi+1].state_reg != ST_IDLE);
      end

      // Layer state machine and registered start pulse.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= ST_IDLE;
          start_reg <= 1'b0;
        end else begin
          start_reg <= start_w;
          if (start_w) begin
            state_reg <= ST_RUN;
          end else if ((state_reg == ST_DONE) && release_w) begin
            state_reg <= ST_IDLE;
          end else if (done_ok_vec[gi] && i_layer_done[gi]) begin
            state_reg <= ST_DONE;
          end
        end
      end

`ifdef CIM_PIPELINE_PERF_CNT_EN
      logic [cycle_cnt_width-1:0] run_cnt_reg;

      // Count RUN cycles, holding at all-ones rather than wrapping.
      always_ff @(posedge clk) begin
        if (rst) begin
          run_cnt_reg <= '0;
        end else if ((state_reg == ST_RUN) && (run_cnt_reg != '1)) begin
          run_cnt_reg <= run_cnt_reg + 1'b1;
        end
      end

      assign o_run_cycles[gi*cycle_cnt_width +: cycle_cnt_width] = run_cnt_reg;
`else
      assign o_run_cycles[gi*cycle_cnt_width +: cycle_cnt_width] = '0;
`endif
    end
  endgenerate

  assign retire         = done_vec[num_layers-1] && i_result_ready;
  assign o_frame_ready  = idle_vec[0];
  assign o_result_valid = done_vec[num_layers-1];
  assign o_idle         = &idle_vec;
  assign o_frame_cnt    = frame_cnt_reg;
  assign o_err          = err_reg;

  // Retired-frame counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (retire) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  // Sticky error flag for done pulses that arrive outside a valid RUN window.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (|(i_layer_done & ~done_ok_vec)) begin
      err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cim_pipeline_seq.sv
// Bench for cim_pipeline_seq (7 layers, 2-bit frame counter).
// A table of per-cycle vectors covers reset, stray done pulses and reset
// while layers are running. Hand-written sequences cover a single frame,
// counter wrap, back-pressure and the run-cycle counter.
module tb_cim_pipeline_seq;
  localparam int NL = 7;
  localparam int FW = 2;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_frame_valid = 1'b0;
  logic             o_frame_ready;
  logic [NL-1:0]    o_layer_start;
  logic [NL-1:0]    i_layer_done = '0;
  logic [NL-1:0]    o_next_busy;
  logic             o_result_valid;
  logic             i_result_ready = 1'b1;
  logic [FW-1:0]    o_frame_cnt;
  logic             o_idle;
  logic             o_err;
  logic [NL*CW-1:0] o_run_cycles;

  cim_pipeline_seq #(
    .num_layers(NL), .frame_cnt_width(FW), .cycle_cnt_width(CW)
  ) dut (
    .clk(clk), .rst(rst), .i_frame_valid(i_frame_valid),
    .o_frame_ready(o_frame_ready), .o_layer_start(o_layer_start),
    .i_layer_done(i_layer_done), .o_next_busy(o_next_busy),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_frame_cnt(o_frame_cnt), .o_idle(o_idle), .o_err(o_err),
    .o_run_cycles(o_run_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rst;
    bit            fv;
    logic [NL-1:0] done;
    logic [NL-1:0] e_start;
    bit            e_fr;
    bit            e_rv;
    bit            e_idle;
    bit            e_err;
    logic [NL-1:0] e_nb;
    logic [FW-1:0] e_fc;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  // Auto-responder: answers each start pulse with a done pulse 3 cycles later.
  bit   auto_en = 1'b0;
  int   resp_cnt [NL];
  bit   log_en = 1'b0;
  int   start_log[$];
  int   l0_starts = 0;
  logic [FW-1:0] exp_fc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    logic [NL-1:0] d;
    @(posedge clk);
    #1;
    d = '0;
    for (int k = 0; k < NL; k++) begin
      if (resp_cnt[k] > 0) resp_cnt[k]--;
      if (o_layer_start[k]) begin
        resp_cnt[k] = 4;
        if (log_en) start_log.push_back(k);
        if (k == 0) l0_starts++;
      end
      d[k] = (resp_cnt[k] == 1);
    end
    if (auto_en) i_layer_done = d;
  endtask

  task automatic set_auto(input bit en);
    for (int k = 0; k < NL; k++) resp_cnt[k] = 0;
    auto_en      = en;
    i_layer_done = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_frame_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_fc = '0;
  endtask

  task automatic add(input bit r, input bit fv, input logic [NL-1:0] dn,
                     input logic [NL-1:0] st, input bit fr, input bit rv,
                     input bit idl, input bit er, input logic [NL-1:0] nb,
                     input logic [FW-1:0] fc);
    vec_t v;
    v.rst = r; v.fv = fv; v.done = dn; v.e_start = st; v.e_fr = fr;
    v.e_rv = rv; v.e_idle = idl; v.e_err = er; v.e_nb = nb; v.e_fc = fc;
    vecs.push_back(v);
  endtask

  task automatic run_frame(input bit check_order);
    int n;
    bit rv_seen;
    n = 0;
    rv_seen = 1'b0;
    start_log.delete();
    log_en = 1'b1;
    i_frame_valid = 1'b1;
    tick();
    i_frame_valid = 1'b0;
    while (!o_idle && n < 200) begin
      if (o_result_valid) rv_seen = 1'b1;
      tick();
      n++;
    end
    log_en = 1'b0;
    check("frame_done_in_time", 32'(n < 200), 1);
    exp_fc = exp_fc + 1'b1;
    check("frame_cnt", 32'(o_frame_cnt), 32'(exp_fc));
    check("idle_after_frame", 32'(o_idle), 1);
    if (check_order) begin
      check("start_count", start_log.size(), NL);
      for (int i = 0; i < start_log.size() && i < NL; i++)
        check($sformatf("start_order[%0d]", i), start_log[i], i);
      check("result_valid_seen", 32'(rv_seen), 1);
    end
  endtask

  initial begin
    int n;
    int exp_rc;

    // rst fv done  | start fr rv idle err nb fc
    add(1, 0, 7'h00, 7'h00, 1, 0, 1, 0, 7'h00, 0); // reset state
    add(0, 0, 7'h00, 7'h00, 1, 0, 1, 0, 7'h00, 0);
    add(0, 0, 7'h04, 7'h00, 1, 0, 1, 1, 7'h00, 0); // stray done on idle layer 2
    add(0, 0, 7'h00, 7'h00, 1, 0, 1, 1, 7'h00, 0); // err is sticky
    add(1, 0, 7'h00, 7'h00, 1, 0, 1, 0, 7'h00, 0); // only reset clears err
    add(0, 1, 7'h00, 7'h01, 0, 0, 0, 0, 7'h00, 0); // 1-cycle start latency
    add(0, 0, 7'h00, 7'h00, 0, 0, 0, 0, 7'h00, 0);
    add(0, 0, 7'h01, 7'h00, 0, 0, 0, 0, 7'h00, 0); // L0 DONE
    add(0, 1, 7'h00, 7'h03, 0, 0, 0, 0, 7'h01, 0); // L1 consumes, L0 restarts
    add(0, 0, 7'h00, 7'h00, 0, 0, 0, 0, 7'h01, 0);
    add(0, 0, 7'h03, 7'h00, 0, 0, 0, 0, 7'h01, 0);
    add(0, 1, 7'h00, 7'h07, 0, 0, 0, 0, 7'h03, 0);
    add(0, 0, 7'h00, 7'h00, 0, 0, 0, 0, 7'h03, 0);
    add(0, 0, 7'h07, 7'h00, 0, 0, 0, 0, 7'h03, 0);
    add(0, 1, 7'h00, 7'h0F, 0, 0, 0, 0, 7'h07, 0); // layers 0-3 RUN
    add(1, 1, 7'h01, 7'h00, 1, 0, 1, 0, 7'h00, 0); // reset mid-run discards inputs
    add(0, 0, 7'h00, 7'h00, 1, 0, 1, 0, 7'h00, 0); // no start pulse after reset
    add(0, 1, 7'h00, 7'h01, 0, 0, 0, 0, 7'h00, 0);
    add(0, 0, 7'h01, 7'h00, 0, 0, 0, 1, 7'h00, 0); // done in start-pulse cycle
    add(0, 0, 7'h01, 7'h00, 0, 0, 0, 1, 7'h00, 0); // now accepted -> DONE
    add(1, 0, 7'h00, 7'h00, 1, 0, 1, 0, 7'h00, 0);

    set_auto(1'b0);
    i_result_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst           = vecs[i].rst;
      i_frame_valid = vecs[i].fv;
      i_layer_done  = vecs[i].done;
      tick();
      check($sformatf("row%0d start", i), 32'(o_layer_start), 32'(vecs[i].e_start));
      check($sformatf("row%0d frame_ready", i), 32'(o_frame_ready), 32'(vecs[i].e_fr));
      check($sformatf("row%0d result_valid", i), 32'(o_result_valid), 32'(vecs[i].e_rv));
      check($sformatf("row%0d idle", i), 32'(o_idle), 32'(vecs[i].e_idle));
      check($sformatf("row%0d err", i), 32'(o_err), 32'(vecs[i].e_err));
      check($sformatf("row%0d next_busy", i), 32'(o_next_busy), 32'(vecs[i].e_nb));
      check($sformatf("row%0d frame_cnt", i), 32'(o_frame_cnt), 32'(vecs[i].e_fc));
    end
    rst = 1'b0;
    i_frame_valid = 1'b0;
    i_layer_done = '0;
    check("run_cycles_after_reset", 32'(o_run_cycles == '0), 1);

    // Single frame through all layers, then four more: counter 1,2,3,0,1.
    do_reset();
    set_auto(1'b1);
    run_frame(1'b1);
    for (int f = 0; f < 4; f++) run_frame(1'b0);
    check("err_clean_after_frames", 32'(o_err), 0);

    // Back-pressure: consumer stalled while frames keep arriving.
    do_reset();
    set_auto(1'b1);
    i_result_ready = 1'b0;
    l0_starts = 0;
    i_frame_valid = 1'b1;
    for (int c = 0; c < 200; c++) tick();
    check("bp_frames_accepted", l0_starts, NL);
    check("bp_frame_ready", 32'(o_frame_ready), 0);
    check("bp_result_valid", 32'(o_result_valid), 1);
    check("bp_idle", 32'(o_idle), 0);
    check("bp_next_busy", 32'(o_next_busy), 32'h7F);
    check("bp_frame_cnt", 32'(o_frame_cnt), 0);
    i_frame_valid = 1'b0;
    i_result_ready = 1'b1;
    tick();
    exp_fc = exp_fc + 1'b1;
    check("bp_first_retire", 32'(o_frame_cnt), 32'(exp_fc));
    n = 0;
    while (!o_idle && n < 300) begin
      tick();
      n++;
    end
    check("bp_drain_in_time", 32'(n < 300), 1);
    exp_fc = exp_fc + 2'd2; // six more frames on a 2-bit counter: 1 + 6 = 7 -> 3
    check("bp_final_frame_cnt", 32'(o_frame_cnt), 32'(exp_fc));
    check("bp_no_extra_accept", l0_starts, NL);
    check("bp_err", 32'(o_err), 0);

    // Layer 1 RUN for exactly 10 cycles.
    do_reset();
    set_auto(1'b0);
    i_frame_valid = 1'b1; tick();
    i_frame_valid = 1'b0; tick();
    i_layer_done = 7'h01; tick();
    i_layer_done = 7'h00; tick();   // layer 1 starts on this edge
    check("rc_l1_start", 32'(o_layer_start), 32'h02);
    for (int c = 0; c < 9; c++) tick();
    i_layer_done = 7'h02; tick();
    i_layer_done = 7'h00;
`ifdef CIM_PIPELINE_PERF_CNT_EN
    exp_rc = 10;
`else
    exp_rc = 0;
`endif
    check("rc_layer1", o_run_cycles[1*CW +: CW], 32'(exp_rc));
    tick();
    check("rc_layer1_hold", o_run_cycles[1*CW +: CW], 32'(exp_rc));
    check("rc_err", 32'(o_err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard time bound so the bench always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
